// File: rtl/pma_region_table_if.sv
// -----------------------------------------------------------------------------
// pma_region_table_if
// Lookup channel of the physical-memory-attribute table. It carries a
// valid/ready request that holds a physical address, and a valid/ready
// response that returns the hit flag, the index of the winning entry and the
// attribute bits.
//
// Signals
//   req_valid   requester -> table  lookup request valid
//   req_ready   table -> requester  request accepted when valid & ready
//   req_addr    requester -> table  physical address to classify
//   resp_valid  table -> requester  lookup result valid
//   resp_ready  requester -> table  consumer accepts the result
//   resp_hit    table -> requester  address matched an enabled entry
//   resp_idx    table -> requester  matching entry index (0 on miss)
//   resp_attr   table -> requester  {exec, cached, idempotent}
// -----------------------------------------------------------------------------
interface pma_region_table_if #(
  parameter int unsigned AddrWidth = 56,
  parameter int unsigned IdxW      = 3
);
  logic                 req_valid;
  logic                 req_ready;
  logic [AddrWidth-1:0] req_addr;
  logic                 resp_valid;
  logic                 resp_ready;
  logic                 resp_hit;
  logic [IdxW-1:0]      resp_idx;
  logic [2:0]           resp_attr;

  modport master (
    output req_valid, req_addr, resp_ready,
    input  req_ready, resp_valid, resp_hit, resp_idx, resp_attr
  );

  modport slave (
    input  req_valid, req_addr, resp_ready,
    output req_ready, resp_valid, resp_hit, resp_idx, resp_attr
  );
endinterface

// File: rtl/pma_region_table.sv
// -----------------------------------------------------------------------------
// pma_region_table
// Runtime-programmable physical-memory-attribute table. It holds NrRegions
// base/length entries, and each entry has {exec, cached, idempotent} attribute
// bits and a sticky lock. Address lookups pass through a two-stage valid/ready
// pipe. The lowest-indexed enabled entry that contains the address wins. An
// address that matches no entry gets DefaultAttr.
//
// Ports
//   clk_i, rst_ni   clock and asynchronous active-low reset
//   cfg_we_i        write entry cfg_idx_i with base/len/attr, lock |= cfg_lock_i
//   cfg_idx_i       entry index
//   cfg_base_i      region base address
//   cfg_len_i       region length in bytes, 0 disables the entry
//   cfg_attr_i      {exec, cached, idempotent}
//   cfg_lock_i      lock the entry until the next reset
//   cfg_err_o       one-cycle pulse: the previous write was rejected
//   lk              lookup request/response channel (slave side)
//
// IdxW is derived from NrRegions. It is exposed only so that it can size the
// ports, and it must not be overridden.
// -----------------------------------------------------------------------------
module pma_region_table #(
  parameter int unsigned NrRegions   = 8,
  parameter int unsigned AddrWidth   = 56,
  parameter logic [2:0]  DefaultAttr = 3'b000,
  parameter int unsigned IdxW        = (NrRegions > 1) ? $clog2(NrRegions) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 cfg_we_i,
  input  logic [IdxW-1:0]      cfg_idx_i,
  input  logic [AddrWidth-1:0] cfg_base_i,
  input  logic [AddrWidth-1:0] cfg_len_i,
  input  logic [2:0]           cfg_attr_i,
  input  logic                 cfg_lock_i,
  output logic                 cfg_err_o,
  pma_region_table_if.slave    lk
);

  // Table storage
  logic [AddrWidth-1:0]      base_q [NrRegions];
  logic [AddrWidth-1:0]      base_d [NrRegions];
  logic [AddrWidth-1:0]      len_q  [NrRegions];
  logic [AddrWidth-1:0]      len_d  [NrRegions];
  logic [NrRegions-1:0][2:0] attr_q, attr_d;
  logic [NrRegions-1:0]      lock_q, lock_d;
  logic                      cfg_err_q, cfg_err_d;

  // Config decode
  logic                      idx_in_range_s;
  logic                      idx_locked_s;
  logic                      wr_ok_s;
  logic [NrRegions-1:0]      wr_sel_s;

  // Per-entry match
  logic [AddrWidth:0]        end_s [NrRegions];
  logic [NrRegions-1:0]      hit_s;

  // Pipeline
  logic                      s1_ready_s, s2_ready_s;
  logic                      s1_v_q, s1_v_d;
  logic [NrRegions-1:0]      s1_hit_q, s1_hit_d;
  logic [NrRegions-1:0][2:0] s1_attr_q, s1_attr_d;
  logic                      pe_hit_s;
  logic [IdxW-1:0]           pe_idx_s;
  logic [2:0]                pe_attr_s;
  logic                      s2_v_q, s2_v_d;
  logic                      s2_hit_q, s2_hit_d;
  logic [IdxW-1:0]           s2_idx_q, s2_idx_d;
  logic [2:0]                s2_attr_q, s2_attr_d;

  // Config write decode: the index must name a real entry, and that entry must be unlocked.
  always_comb begin
    idx_in_range_s = 1'b0;
    idx_locked_s   = 1'b0;
    for (int i = 0; i < NrRegions; i++) begin
      // Compare against every legal index so that an out-of-range index never reads past the table.
      idx_in_range_s = idx_in_range_s | (cfg_idx_i == IdxW'(i));
      idx_locked_s   = idx_locked_s | ((cfg_idx_i == IdxW'(i)) & lock_q[i]);
    end
    wr_ok_s   = cfg_we_i & idx_in_range_s & ~idx_locked_s;
    cfg_err_d = cfg_we_i & ~wr_ok_s;
    for (int i = 0; i < NrRegions; i++) begin
      wr_sel_s[i] = wr_ok_s & (cfg_idx_i == IdxW'(i));
    end
  end

  // Next table contents. A write that sets lock takes effect together with the data it writes.
  always_comb begin
    attr_d = attr_q;
    lock_d = lock_q;
    for (int i = 0; i < NrRegions; i++) begin
      if (wr_sel_s[i]) begin
        base_d[i] = cfg_base_i;
        len_d[i]  = cfg_len_i;
        attr_d[i] = cfg_attr_i;
        lock_d[i] = lock_q[i] | cfg_lock_i;
      end else begin
        base_d[i] = base_q[i];
        len_d[i]  = len_q[i];
      end
    end
  end

  // Table registers and the write-error pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NrRegions; i++) begin
        base_q[i] <= {AddrWidth{1'b0}};
        len_q[i]  <= {AddrWidth{1'b0}};
      end
      attr_q    <= {(NrRegions*3){1'b0}};
      lock_q    <= {NrRegions{1'b0}};
      cfg_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < NrRegions; i++) begin
        base_q[i] <= base_d[i];
        len_q[i]  <= len_d[i];
      end
      attr_q    <= attr_d;
      lock_q    <= lock_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  // Per-entry match against the current table. The end address is one bit wider, so a region
  // that ends exactly at the top of the address space does not wrap.
  always_comb begin
    for (int i = 0; i < NrRegions; i++) begin
      end_s[i] = {1'b0, base_q[i]} + {1'b0, len_q[i]};
      hit_s[i] = (len_q[i] != {AddrWidth{1'b0}}) &&
                 (lk.req_addr >= base_q[i]) &&
                 ({1'b0, lk.req_addr} < end_s[i]);
    end
  end

  // Priority-encode the S1 snapshot. Scanning downward lets the lowest matching index win.
  always_comb begin
    pe_hit_s  = 1'b0;
    pe_idx_s  = {IdxW{1'b0}};
    pe_attr_s = DefaultAttr;
    for (int i = NrRegions - 1; i >= 0; i--) begin
      pe_hit_s  = pe_hit_s | s1_hit_q[i];
      pe_idx_s  = s1_hit_q[i] ? IdxW'(i) : pe_idx_s;
      pe_attr_s = s1_hit_q[i] ? s1_attr_q[i] : pe_attr_s;
    end
  end

  // Pipe handshake and stage advance. S1 snapshots the attributes together with the hit
  // vector, so a table write after acceptance cannot change a result that is in flight.
  always_comb begin
    s2_ready_s = ~s2_v_q | lk.resp_ready;
    s1_ready_s = ~s1_v_q | s2_ready_s;

    if (s1_ready_s && lk.req_valid) begin
      s1_v_d    = 1'b1;
      s1_hit_d  = hit_s;
      s1_attr_d = attr_q;
    end else if (s1_ready_s) begin
      s1_v_d    = 1'b0;
      s1_hit_d  = s1_hit_q;
      s1_attr_d = s1_attr_q;
    end else begin
      s1_v_d    = s1_v_q;
      s1_hit_d  = s1_hit_q;
      s1_attr_d = s1_attr_q;
    end

    if (s2_ready_s && s1_v_q) begin
      s2_v_d    = 1'b1;
      s2_hit_d  = pe_hit_s;
      s2_idx_d  = pe_idx_s;
      s2_attr_d = pe_attr_s;
    end else if (s2_ready_s) begin
      s2_v_d    = 1'b0;
      s2_hit_d  = s2_hit_q;
      s2_idx_d  = s2_idx_q;
      s2_attr_d = s2_attr_q;
    end else begin
      s2_v_d    = s2_v_q;
      s2_hit_d  = s2_hit_q;
      s2_idx_d  = s2_idx_q;
      s2_attr_d = s2_attr_q;
    end
  end

  // Pipeline registers. Reset drops every lookup that is in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_v_q    <= 1'b0;
      s1_hit_q  <= {NrRegions{1'b0}};
      s1_attr_q <= {(NrRegions*3){1'b0}};
      s2_v_q    <= 1'b0;
      s2_hit_q  <= 1'b0;
      s2_idx_q  <= {IdxW{1'b0}};
      s2_attr_q <= 3'b000;
    end else begin
      s1_v_q    <= s1_v_d;
      s1_hit_q  <= s1_hit_d;
      s1_attr_q <= s1_attr_d;
      s2_v_q    <= s2_v_d;
      s2_hit_q  <= s2_hit_d;
      s2_idx_q  <= s2_idx_d;
      s2_attr_q <= s2_attr_d;
    end
  end

  assign cfg_err_o     = cfg_err_q;
  assign lk.req_ready  = s1_ready_s;
  assign lk.resp_valid = s2_v_q;
  assign lk.resp_hit   = s2_hit_q;
  assign lk.resp_idx   = s2_idx_q;
  assign lk.resp_attr  = s2_attr_q;

endmodule

// File: tb/tb_pma_region_table.sv
// -----------------------------------------------------------------------------
// tb_pma_region_table
// Self-checking bench for pma_region_table. It instantiates the design with 6
// entries so that indices 6 and 7 are out of range. A behavioural model holds
// the table and a queue of expected results. Directed scenarios pin known
// values, and a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_pma_region_table;
  localparam int NR = 6;
  localparam int AW = 56;
  localparam int IW = 3;
  localparam logic [2:0] DEF = 3'b000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_we;
  logic [IW-1:0] cfg_idx;
  logic [AW-1:0] cfg_base;
  logic [AW-1:0] cfg_len;
  logic [2:0]    cfg_attr;
  logic          cfg_lock;
  logic          cfg_err;

  pma_region_table_if #(.AddrWidth(AW), .IdxW(IW)) lk ();

  pma_region_table #(
    .NrRegions(NR), .AddrWidth(AW), .DefaultAttr(DEF), .IdxW(IW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .cfg_we_i(cfg_we), .cfg_idx_i(cfg_idx),
    .cfg_base_i(cfg_base), .cfg_len_i(cfg_len), .cfg_attr_i(cfg_attr),
    .cfg_lock_i(cfg_lock), .cfg_err_o(cfg_err), .lk(lk)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  bit saw_low  = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic          hit;
    logic [IW-1:0] idx;
    logic [2:0]    attr;
    int            acc;   // edge number at which the request was accepted
  } item_t;

  logic [AW-1:0] m_base [NR];
  logic [AW-1:0] m_len  [NR];
  logic [2:0]    m_attr [NR];
  logic          m_lock [NR];
  item_t         q[$];
  logic          err_pend = 1'b0;
  int            ecnt = 0;

  // An entry contains a if a lies in [base, base+len). The lowest such entry wins.
  function automatic item_t m_lookup(input logic [AW-1:0] a);
    item_t r;
    r.hit = 1'b0; r.idx = '0; r.attr = DEF; r.acc = 0;
    for (int i = 0; i < NR; i++) begin
      if (!r.hit && m_len[i] != '0 && a >= m_base[i] && (a - m_base[i]) < m_len[i]) begin
        r.hit  = 1'b1;
        r.idx  = IW'(i);
        r.attr = m_attr[i];
      end
    end
    return r;
  endfunction

  // The compare process samples on every falling edge, then advances the model to the next edge.
  initial begin
    bit    vis, rdy;
    item_t it;
    int    k;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        for (int i = 0; i < NR; i++) begin
          m_base[i] = '0; m_len[i] = '0; m_attr[i] = 3'b000; m_lock[i] = 1'b0;
        end
        q.delete();
        err_pend = 1'b0;
        chk("rst_resp_valid", 64'(lk.resp_valid), 64'(1'b0));
        chk("rst_resp_hit",   64'(lk.resp_hit),   64'(1'b0));
        chk("rst_resp_idx",   64'(lk.resp_idx),   64'(0));
        chk("rst_resp_attr",  64'(lk.resp_attr),  64'(0));
        chk("rst_cfg_err",    64'(cfg_err),       64'(1'b0));
        chk("rst_req_ready",  64'(lk.req_ready),  64'(1'b1));
      end else begin
        rdy = (q.size() < 2) || (lk.resp_ready === 1'b1);
        vis = (q.size() > 0) && (q[0].acc < ecnt);
        chk("req_ready",  64'(lk.req_ready),  64'(rdy));
        chk("resp_valid", 64'(lk.resp_valid), 64'(vis));
        if (vis) begin
          chk("resp_hit",  64'(lk.resp_hit),  64'(q[0].hit));
          chk("resp_idx",  64'(lk.resp_idx),  64'(q[0].idx));
          chk("resp_attr", 64'(lk.resp_attr), 64'(q[0].attr));
        end
        chk("cfg_err", 64'(cfg_err), 64'(err_pend));
        if (vis && lk.resp_ready) void'(q.pop_front());
        if (lk.req_valid && rdy) begin
          it = m_lookup(lk.req_addr);   // sees the table before this edge's write
          it.acc = ecnt + 1;
          q.push_back(it);
        end
        k = int'(cfg_idx);
        err_pend = cfg_we && ((k >= NR) || m_lock[k]);
        if (cfg_we && !err_pend) begin
          m_base[k] = cfg_base; m_len[k] = cfg_len; m_attr[k] = cfg_attr;
          m_lock[k] = m_lock[k] | cfg_lock;
        end
        ecnt++;
      end
    end
  end

  // ---------------- stimulus helpers (all start and end at posedge+1) ----------------
  task automatic cfg_write(input logic [IW-1:0] idx, input logic [AW-1:0] base,
                           input logic [AW-1:0] len, input logic [2:0] attr,
                           input logic lock, input logic exp_err, input string name);
    cfg_we = 1'b1; cfg_idx = idx; cfg_base = base; cfg_len = len;
    cfg_attr = attr; cfg_lock = lock;
    @(posedge clk); #1 cfg_we = 1'b0;
    @(negedge clk);
    chk(name, 64'(cfg_err), 64'(exp_err));
    @(posedge clk); #1;
  endtask

  task automatic lookup_chk(input logic [AW-1:0] a, input logic eh, input logic [IW-1:0] ei,
                            input logic [2:0] ea, input string name);
    item_t m;
    m = m_lookup(a);
    chk({name, "_model"}, 64'({m.hit, m.idx, m.attr}), 64'({eh, ei, ea}));
    lk.req_valid = 1'b1; lk.req_addr = a;
    @(posedge clk); #1 lk.req_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk({name, "_valid"}, 64'(lk.resp_valid), 64'(1'b1));
    chk({name, "_hit"},   64'(lk.resp_hit),   64'(eh));
    chk({name, "_idx"},   64'(lk.resp_idx),   64'(ei));
    chk({name, "_attr"},  64'(lk.resp_attr),  64'(ea));
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [AW-1:0] a);
    bit done;
    done = 1'b0;
    lk.req_valid = 1'b1; lk.req_addr = a;
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clk);
      done = lk.req_ready;
      if (!done) saw_low = 1'b1;
      @(posedge clk); #1;
    end
    chk("send_accepted", 64'(done), 64'(1'b1));
  endtask

  // Global time bound
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [63:0] r64;
    rst_n = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_base = '0; cfg_len = '0;
    cfg_attr = 3'b000; cfg_lock = 1'b0;
    lk.req_valid = 1'b0; lk.req_addr = '0; lk.resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // basic hit / miss
    cfg_write(3'd0, 56'h8000_0000, 56'h4000_0000, 3'b111, 1'b0, 1'b0, "wr_idx0");
    lookup_chk(56'h8000_0010, 1'b1, 3'd0, 3'b111, "basic_hit");
    lookup_chk(56'hC000_0000, 1'b0, 3'd0, DEF,    "basic_miss");

    // top of address space and a disabled entry
    cfg_write(3'd3, 56'hFF_FFFF_FFFF_F000, 56'h1000, 3'b101, 1'b0, 1'b0, "wr_top");
    lookup_chk(56'hFF_FFFF_FFFF_FFFF, 1'b1, 3'd3, 3'b101, "top_hit");
    cfg_write(3'd4, 56'h5000, 56'h0, 3'b111, 1'b0, 1'b0, "wr_len0");
    lookup_chk(56'h5000, 1'b0, 3'd0, DEF, "len0_miss");

    // overlap priority
    cfg_write(3'd2, 56'h1_0000, 56'h1_0000,  3'b100, 1'b0, 1'b0, "wr_idx2");
    cfg_write(3'd5, 56'h0,      56'h10_0000, 3'b011, 1'b0, 1'b0, "wr_idx5");
    lookup_chk(56'h1_8000, 1'b1, 3'd2, 3'b100, "ovl_low_wins");
    lookup_chk(56'h2_0000, 1'b1, 3'd5, 3'b011, "ovl_outer");

    // lock and out-of-range index
    cfg_write(3'd1, 56'h20_0000, 56'h1000, 3'b010, 1'b1, 1'b0, "wr_lock");
    cfg_write(3'd1, 56'h20_0000, 56'h1000, 3'b101, 1'b0, 1'b1, "wr_locked_err");
    lookup_chk(56'h20_0000, 1'b1, 3'd1, 3'b010, "locked_keeps");
    cfg_write(3'd6, 56'h0, 56'h10, 3'b111, 1'b0, 1'b1, "wr_idx_nr_err");
    cfg_write(3'd7, 56'h0, 56'h10, 3'b111, 1'b0, 1'b1, "wr_idx7_err");

    // a write in the same cycle as a lookup is seen only by the following lookup
    cfg_we = 1'b1; cfg_idx = 3'd0; cfg_base = 56'h8000_0000; cfg_len = 56'h4000_0000;
    cfg_attr = 3'b001; cfg_lock = 1'b0;
    lk.req_valid = 1'b1; lk.req_addr = 56'h8000_0010;
    @(posedge clk); #1 cfg_we = 1'b0;
    @(posedge clk); #1 lk.req_valid = 1'b0;
    @(negedge clk);
    chk("order_old_attr", 64'(lk.resp_attr), 64'(3'b111));
    @(posedge clk); #1;
    @(negedge clk);
    chk("order_new_attr", 64'(lk.resp_attr), 64'(3'b001));
    @(posedge clk); #1;
    repeat (2) @(posedge clk); #1;

    // backpressure: 5 back-to-back requests while resp_ready is held low for 3 cycles
    saw_low = 1'b0;
    lk.resp_ready = 1'b0;
    fork
      begin
        repeat (3) @(posedge clk);
        #1 lk.resp_ready = 1'b1;
      end
      begin
        send(56'h8000_0000);
        send(56'h1_8000);
        send(56'h2_0000);
        send(56'hC000_0000);
        send(56'h20_0800);
        lk.req_valid = 1'b0;
      end
    join
    chk("bp_ready_dropped", 64'(saw_low), 64'(1'b1));
    repeat (6) @(posedge clk); #1;

    // reset with two lookups in flight
    lk.resp_ready = 1'b0;
    send(56'h1_8000);
    send(56'h2_0000);
    lk.req_valid = 1'b0;
    chk("pre_rst_valid", 64'(lk.resp_valid), 64'(1'b1));
    #1 rst_n = 1'b0;
    #1 chk("rst_drop_valid", 64'(lk.resp_valid), 64'(1'b0));
    @(posedge clk); #1;
    @(posedge clk); #1 rst_n = 1'b1;
    lk.resp_ready = 1'b1;
    repeat (4) @(posedge clk); #1;
    cfg_write(3'd1, 56'h20_0000, 56'h1000, 3'b110, 1'b0, 1'b0, "wr_after_rst");
    lookup_chk(56'h20_0000, 1'b1, 3'd1, 3'b110, "after_rst_hit");

    // randomized traffic, with one reset in the middle
    for (int c = 0; c < 3000; c++) begin
      lk.req_valid = ($urandom_range(9, 0) < 7);
      case ($urandom_range(9, 0))
        8:       lk.req_addr = 56'hFF_FFFF_FFFF_F000 + 56'($urandom_range(32'h1FFF, 32'h0));
        9:       begin r64 = {$urandom(), $urandom()}; lk.req_addr = r64[AW-1:0]; end
        default: lk.req_addr = 56'($urandom_range(32'h13_FFFF, 32'h0));
      endcase
      lk.resp_ready = ($urandom_range(9, 0) < 7);
      cfg_we   = ($urandom_range(15, 0) == 0);
      cfg_idx  = IW'($urandom_range(7, 0));
      cfg_base = ($urandom_range(15, 0) == 0) ? 56'hFF_FFFF_FFFF_E000
                                             : 56'($urandom_range(32'hF_FFFF, 32'h0));
      cfg_len  = ($urandom_range(7, 0) == 0) ? 56'h0 : 56'($urandom_range(32'h4_0000, 32'h1));
      cfg_attr = 3'($urandom_range(7, 0));
      cfg_lock = ($urandom_range(31, 0) == 0);
      if (c == 1500) begin
        #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
      end else begin
        @(posedge clk); #1;
      end
    end

    lk.req_valid = 1'b0; cfg_we = 1'b0; lk.resp_ready = 1'b1;
    repeat (6) @(posedge clk); #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
